// File: rtl/ssp_tx_sequencer_pkg.sv
// Shared definitions for the SSP transmit sequencer: default frame width
// and the sequencer state encoding.
package ssp_tx_sequencer_pkg;

   // Default serial frame length in bits (also the FIFO data width)
   localparam int SSP_DATA_WIDTH = 8;

   // Sequencer states, kept as plain constants so legacy code can compare them
   localparam logic [1:0] ST_IDLE  = 2'd0;   // line idle, output disabled
   localparam logic [1:0] ST_FRAME = 2'd1;   // frame sync period before the MSB
   localparam logic [1:0] ST_SHIFT = 2'd2;   // shifting data bits, MSB first

endpackage

// File: rtl/ssp_tx_sequencer.sv
// SSP transmit sequencer: pops bytes from a transmit FIFO into a one-entry
// holding register and shifts them out MSB first on a PCLK/2 serial clock,
// with a one-period frame sync ahead of each frame and seamless back-to-back
// frames when the next byte is already waiting.
module ssp_tx_sequencer
   import ssp_tx_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH = SSP_DATA_WIDTH
) (
   input  logic                  PCLK,
   input  logic                  CLEAR,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] TxData,
   output logic                  shf_read_ready,
   output logic                  SSPCLKOUT,
   output logic                  SSPFSSOUT,
   output logic                  SSPTXD,
   output logic                  SSPOE_B,
   output logic                  tx_busy
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0] BIDX_TOP  = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] BIDX_ONE  = BW'(1);
   localparam logic [BW-1:0] BIDX_ZERO = '0;

   logic [1:0]            state_reg;
   logic                  ph_reg;
   logic [DATA_WIDTH-1:0] hold_reg;
   logic                  hold_valid_reg;
   logic [DATA_WIDTH-1:0] sreg_reg;
   logic [BW-1:0]         bidx_reg;
   logic                  rd_req_reg;    // pop request presented to the FIFO
   logic                  rd_wait_reg;   // FIFO read data arrives this cycle
   logic                  fss_reg;
   logic                  txd_reg;
   logic                  oe_b_reg;
   logic                  tick;

   // A tick is the edge where the serial clock rises (ph goes 0 -> 1)
   assign tick = ~ph_reg;

   // Serial clock divider: ph toggles on every PCLK edge outside reset
   always_ff @(posedge PCLK) begin
      if (CLEAR) begin
         ph_reg <= 1'b0;
      end else begin
         ph_reg <= ~ph_reg;
      end
   end

   // FIFO fetch: one pop at a time, only while the holding register is empty
   always_ff @(posedge PCLK) begin
      if (CLEAR) begin
         rd_req_reg  <= 1'b0;
         rd_wait_reg <= 1'b0;
         hold_reg    <= '0;
      end else begin
         rd_req_reg  <= ~hold_valid_reg & ~fifo_empty & ~rd_req_reg & ~rd_wait_reg;
         rd_wait_reg <= rd_req_reg;
         if (rd_wait_reg) begin
            hold_reg <= TxData;
         end
      end
   end

   // Frame sequencer; also owns hold_valid since load and transfer both touch it
   always_ff @(posedge PCLK) begin
      if (CLEAR) begin
         state_reg      <= ST_IDLE;
         hold_valid_reg <= 1'b0;
         sreg_reg       <= '0;
         bidx_reg       <= '0;
         fss_reg        <= 1'b0;
         txd_reg        <= 1'b0;
         oe_b_reg       <= 1'b1;
      end else begin
         // A load never coincides with a transfer: pops only happen while hold is empty
         if (rd_wait_reg) begin
            hold_valid_reg <= 1'b1;
         end
         if (tick) begin
            case (state_reg)
               ST_IDLE: begin
                  if (hold_valid_reg) begin
                     state_reg      <= ST_FRAME;
                     fss_reg        <= 1'b1;
                     sreg_reg       <= hold_reg;
                     hold_valid_reg <= 1'b0;
                  end
               end
               ST_FRAME: begin
                  state_reg <= ST_SHIFT;
                  fss_reg   <= 1'b0;
                  oe_b_reg  <= 1'b0;
                  txd_reg   <= sreg_reg[DATA_WIDTH-1];
                  bidx_reg  <= BIDX_TOP;
               end
               ST_SHIFT: begin
                  if (bidx_reg != BIDX_ZERO) begin
                     txd_reg  <= sreg_reg[bidx_reg - BIDX_ONE];
                     bidx_reg <= bidx_reg - BIDX_ONE;
                     // Sync for the next frame overlaps this frame's bit 0
                     if (bidx_reg == BIDX_ONE) begin
                        fss_reg <= hold_valid_reg;
                     end
                  end else if (fss_reg) begin
                     // Back-to-back: next byte's MSB follows bit 0 with no gap
                     sreg_reg       <= hold_reg;
                     hold_valid_reg <= 1'b0;
                     txd_reg        <= hold_reg[DATA_WIDTH-1];
                     bidx_reg       <= BIDX_TOP;
                     fss_reg        <= 1'b0;
                  end else begin
                     state_reg <= ST_IDLE;
                     oe_b_reg  <= 1'b1;
                     txd_reg   <= 1'b0;
                  end
               end
               default: begin
                  state_reg <= ST_IDLE;
                  oe_b_reg  <= 1'b1;
                  txd_reg   <= 1'b0;
                  fss_reg   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign shf_read_ready = rd_req_reg;
   assign SSPCLKOUT      = ph_reg;
   assign SSPFSSOUT      = fss_reg;
   assign SSPTXD         = txd_reg;
   assign SSPOE_B        = oe_b_reg;
   assign tx_busy        = (state_reg != ST_IDLE) | rd_req_reg | rd_wait_reg | hold_valid_reg;

endmodule

// File: doc/ssp_tx_sequencer.md
SSP_TX_SEQUENCER -- requirements
Module: ssp_tx_sequencer

Interface
REQ-001 Parameter: DATA_WIDTH, 8, serial frame length in bits and TxData width.
REQ-002 Single clock PCLK; reset CLEAR is synchronous and active-high.
REQ-003 PCLK  in  1  system clock; all state updates on its rising edge.
REQ-004 CLEAR  in  1  synchronous active-high reset.
REQ-005 fifo_empty  in  1  transmit FIFO holds no entries.
REQ-006 TxData  in  DATA_WIDTH  FIFO read data, valid the cycle after the edge that sampled shf_read_ready=1.
REQ-007 shf_read_ready  out  1  registered one-cycle pop request to the transmit FIFO.
REQ-008 SSPCLKOUT  out  1  serial clock, PCLK/2, free-running outside reset.
REQ-009 SSPFSSOUT  out  1  frame sync, high for one SSPCLKOUT period before each frame's MSB.
REQ-010 SSPTXD  out  1  serial data, MSB first.
REQ-011 SSPOE_B  out  1  active-low output enable for SSPTXD.
REQ-012 tx_busy  out  1  high when state is not IDLE, a fetch is in flight, or the holding register is valid.

Function
REQ-013 Phase bit ph toggles every PCLK edge; SSPCLKOUT = ph; a "tick" is an edge where ph goes 0->1; SSPFSSOUT, SSPTXD, SSPOE_B change only on ticks.
REQ-014 One-byte holding register hold with flag hold_valid; shift register sreg; 3-bit bit counter bidx (log2 DATA_WIDTH bits).
REQ-015 Fetch: when hold_valid=0, fifo_empty=0, no fetch in flight, shf_read_ready SHALL be 1 for exactly the next cycle; hold <= TxData and hold_valid <= 1 on the following edge.
REQ-016 Fetch issue is independent of ph; at most one fetch in flight; no pop issued while hold_valid=1.
REQ-017 States: IDLE, FRAME, SHIFT.
REQ-018 IDLE: SSPOE_B=1, SSPFSSOUT=0, SSPTXD=0; on a tick with hold_valid=1 -> FRAME, SSPFSSOUT<=1, sreg<=hold, hold_valid<=0.
REQ-019 FRAME: on next tick -> SHIFT, SSPFSSOUT<=0, SSPOE_B<=0, SSPTXD<=sreg[MSB], bidx<=DATA_WIDTH-1.
REQ-020 SHIFT, bidx>0: on tick SSPTXD<=sreg[bidx-1], bidx<=bidx-1; SSPFSSOUT<=1 on the tick that drives bit 0 iff hold_valid=1 at that tick.
REQ-021 SHIFT, bidx=0, SSPFSSOUT=1 (back-to-back): on tick sreg<=hold, hold_valid<=0, SSPTXD<=hold[MSB], bidx<=DATA_WIDTH-1, SSPFSSOUT<=0; stay SHIFT, SSPOE_B stays 0.
REQ-022 SHIFT, bidx=0, SSPFSSOUT=0: on tick -> IDLE, SSPOE_B<=1, SSPTXD<=0; hold arriving later starts a new frame from IDLE per REQ-018.
REQ-023 Frame length: 2*DATA_WIDTH PCLK data cycles plus 2-cycle sync period; back-to-back frames have no idle gap.
REQ-024 Latency, IDLE with fifo_empty falling in cycle n: pop in n+1, hold valid n+3, SSPFSSOUT rises on first tick at or after edge ending n+3.
REQ-025 fifo_empty ignored while hold_valid=1 or fetch in flight.

Reset
REQ-026 CLEAR=1 at an edge: state<=IDLE, ph<=0, hold_valid<=0, fetch-in-flight<=0, bidx<=0, sreg<=0, hold<=0.
REQ-027 Output reset values: shf_read_ready=0, SSPCLKOUT=0, SSPFSSOUT=0, SSPTXD=0, SSPOE_B=1, tx_busy=0.
REQ-028 CLEAR mid-frame aborts the frame immediately; in-flight byte and hold contents discarded; no pop issued while CLEAR=1.

Structure
REQ-029 Shared package holds state encoding (IDLE, FRAME, SHIFT) and DATA_WIDTH default.
REQ-030 Single module, no sub-modules; ph divider inline.

Verification
REQ-031 Reset then fifo_empty=1 for 40 cycles -> shf_read_ready never 1, SSPOE_B=1, SSPCLKOUT toggles each cycle.
REQ-032 One byte 8'hA5 -> single pop, SSPFSSOUT high 2 cycles, SSPTXD 1,0,1,0,0,1,0,1 each held 2 cycles, SSPOE_B low 16 cycles, then IDLE.
REQ-033 Two bytes 8'h81, 8'h7E queued -> SSPFSSOUT high during 8'h81 bit 0, 8'h7E MSB on next tick, SSPOE_B low 32 contiguous cycles.
REQ-034 Byte arrives after last bit of 8'hFF driven -> SSPOE_B returns 1, new frame restarts via FRAME, no overlap.
REQ-035 CLEAR pulsed mid-frame at bit 4 of 8'h3C -> next edge all outputs at reset values, no further pop until CLEAR=0.
REQ-036 fifo_empty held 0 throughout 3 frames -> exactly one pop per frame, never two pops without an intervening hold-to-sreg transfer.
